// File: rtl/flag_unit.sv
// Flag register with forwarding condition evaluator and a 4-deep LIFO
// that saves/restores the flags across interrupt entry and return.
package flag_unit_pkg;
   typedef struct packed {
      logic s;
      logic z;
      logic c;
      logic o;
   } csr_t;
endpackage

module flag_unit
   import flag_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flags_we,
   input  csr_t       flags_in,
   input  logic       cond_valid,
   input  logic [2:0] cond_sel,
   input  logic       push,
   input  logic       pop,
   output csr_t       flags_q,
   output logic       cond_ready,
   output logic       cond_taken,
   output logic [2:0] depth,
   output logic       ovf_err,
   output logic       unf_err,
   output logic       proto_err
);

   localparam logic [2:0] DEPTH_MAX = 3'd4;

   csr_t       flags_q_r;
   csr_t       flags_nxt_s;
   csr_t       src_s;
   csr_t       top_s;
   csr_t       stack_r [4];
   logic [2:0] depth_r;
   logic [2:0] depth_nxt_s;
   logic [1:0] top_idx_s;
   logic       push_ok_s;
   logic       pop_ok_s;
   logic       cond_ready_r;
   logic       cond_taken_r;
   logic       ovf_err_r;
   logic       unf_err_r;
   logic       proto_err_r;

   function automatic logic cond_eval(input csr_t f, input logic [2:0] sel);
      logic r;
      case (sel)
         3'b000:  r = 1'b1;
         3'b001:  r = f.z;
         3'b010:  r = ~f.z;
         3'b011:  r = f.c;
         3'b100:  r = ~f.c;
         3'b101:  r = f.s;
         3'b110:  r = f.s ^ f.o;
         3'b111:  r = ~f.z & ~(f.s ^ f.o);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Accept/reject push and pop; pick next flags, depth and evaluation source
   always_comb begin
      push_ok_s   = push & ~pop & (depth_r != DEPTH_MAX);
      pop_ok_s    = pop & ~push & (depth_r != 3'd0);
      // depth=4 wraps to index 3 here, which is the top of a full stack
      top_idx_s   = depth_r[1:0] - 2'd1;
      top_s       = stack_r[top_idx_s];
      flags_nxt_s = flags_q_r;
      src_s       = flags_q_r;
      depth_nxt_s = depth_r;
      if (pop_ok_s) begin
         flags_nxt_s = top_s;
         src_s       = top_s;
         depth_nxt_s = depth_r - 3'd1;
      end else begin
         if (flags_we) begin
            flags_nxt_s = flags_in;
            src_s       = flags_in;
         end else begin
            flags_nxt_s = flags_q_r;
            src_s       = flags_q_r;
         end
         if (push_ok_s) begin
            depth_nxt_s = depth_r + 3'd1;
         end else begin
            depth_nxt_s = depth_r;
         end
      end
   end

   // Architectural state, sticky errors and registered evaluation result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_q_r    <= '0;
         depth_r      <= 3'd0;
         cond_ready_r <= 1'b0;
         cond_taken_r <= 1'b0;
         ovf_err_r    <= 1'b0;
         unf_err_r    <= 1'b0;
         proto_err_r  <= 1'b0;
      end else begin
         flags_q_r    <= flags_nxt_s;
         depth_r      <= depth_nxt_s;
         cond_ready_r <= cond_valid;
         if (cond_valid) begin
            cond_taken_r <= cond_eval(src_s, cond_sel);
         end else begin
            cond_taken_r <= cond_taken_r;
         end
         ovf_err_r   <= ovf_err_r | (push & ~pop & (depth_r == DEPTH_MAX));
         unf_err_r   <= unf_err_r | (pop & ~push & (depth_r == 3'd0));
         proto_err_r <= proto_err_r | (push & pop);
      end
   end

   // Stack storage; contents survive reset but depth=0 hides them
   always_ff @(posedge clk) begin
      if (rst_n && push_ok_s) begin
         stack_r[depth_r[1:0]] <= flags_q_r;
      end
   end

   assign flags_q    = flags_q_r;
   assign cond_ready = cond_ready_r;
   assign cond_taken = cond_taken_r;
   assign depth      = depth_r;
   assign ovf_err    = ovf_err_r;
   assign unf_err    = unf_err_r;
   assign proto_err  = proto_err_r;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: condition results go through a scoreboard
// queue checked by a monitor; state outputs are checked after each cycle.
module tb_flag_unit;
   import flag_unit_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       flags_we;
   csr_t       flags_in;
   logic       cond_valid;
   logic [2:0] cond_sel;
   logic       push;
   logic       pop;
   csr_t       flags_q;
   logic       cond_ready;
   logic       cond_taken;
   logic [2:0] depth;
   logic       ovf_err;
   logic       unf_err;
   logic       proto_err;

   typedef struct {
      logic  taken;
      int    cyc;
      string nm;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_cnt = 0;

   flag_unit dut (
      .clk(clk), .rst_n(rst_n), .flags_we(flags_we), .flags_in(flags_in),
      .cond_valid(cond_valid), .cond_sel(cond_sel), .push(push), .pop(pop),
      .flags_q(flags_q), .cond_ready(cond_ready), .cond_taken(cond_taken),
      .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to pin the one-cycle evaluation latency
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Monitor: every cond_ready must match the oldest outstanding request
   always @(negedge clk) begin : mon
      exp_t e;
      if (cond_ready === 1'b1) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_ready: cond_ready=1 at cycle %0d, no request outstanding", cyc_cnt);
         end else begin
            e = sb_q.pop_front();
            if (cond_taken !== e.taken || cyc_cnt != e.cyc) begin
               n_fail++;
               $display("FAIL cond_%s: got taken=%b at cycle %0d, expected taken=%b at cycle %0d",
                        e.nm, cond_taken, cyc_cnt, e.taken, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic rn, input logic we, input logic [3:0] fi,
                      input logic cv, input logic [2:0] cs, input logic pu,
                      input logic po, input logic et, input string nm);
      rst_n      = rn;
      flags_we   = we;
      flags_in   = fi;
      cond_valid = cv;
      cond_sel   = cs;
      push       = pu;
      pop        = po;
      if (cv && rn) sb_q.push_back('{et, cyc_cnt + 1, nm});
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      flags_we   = 1'b0;
      cond_valid = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_flags"}, flags_q, 4'b0000);
      chk({tag, "_ready"}, {3'b000, cond_ready}, 4'd0);
      chk({tag, "_taken"}, {3'b000, cond_taken}, 4'd0);
      chk({tag, "_depth"}, {1'b0, depth}, 4'd0);
      chk({tag, "_errs"},  {1'b0, ovf_err, unf_err, proto_err}, 4'd0);
   endtask

   initial begin
      rst_n = 1'b0; flags_we = 1'b0; flags_in = '0; cond_valid = 1'b0;
      cond_sel = 3'd0; push = 1'b0; pop = 1'b0;

      // reset, with an evaluation request that must be swallowed
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, "rst");
      cyc(1'b0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "rst");
      chk_all_zero("reset");

      // write S1 Z0 C1 O0, then evaluate carry
      cyc(1'b1, 1'b1, 4'b1010, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "");
      chk("write_flags", flags_q, 4'b1010);
      cyc(1'b1, 1'b0, 4'h0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b1, "carry");
      chk("carry_ready", {3'b000, cond_ready}, 4'd1);
      cyc(1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "");
      chk("idle_ready", {3'b000, cond_ready}, 4'd0);
      chk("idle_taken_hold", {3'b000, cond_taken}, 4'd1);

      // forwarding: Z written in the same cycle as the Z test
      cyc(1'b1, 1'b1, 4'b0100, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, "fwd_z");
      chk("fwd_flags", flags_q, 4'b0100);

      // fill the stack with 0000, 1001, 0110, 1000
      cyc(1'b1, 1'b1, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "");
      cyc(1'b1, 1'b1, 4'b1001, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "");
      cyc(1'b1, 1'b1, 4'b0110, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "");
      cyc(1'b1, 1'b1, 4'b1000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "");
      cyc(1'b1, 1'b1, 4'b0011, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "");
      chk("full_depth", {1'b0, depth}, 4'd4);
      chk("full_flags", flags_q, 4'b0011);
      // 5th push overflows; flags_we still lands and is forwarded
      cyc(1'b1, 1'b1, 4'b0101, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0, "ovf_fwd_c");
      chk("ovf_depth", {1'b0, depth}, 4'd4);
      chk("ovf_err", {3'b000, ovf_err}, 4'd1);
      chk("ovf_flags", flags_q, 4'b0101);
      chk("ovf_unf_clear", {3'b000, unf_err}, 4'd0);

      // pops restore in reverse order; evaluation sees the popped entry
      cyc(1'b1, 1'b0, 4'h0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b1, "pop1_s");
      chk("pop1_flags", flags_q, 4'b1000);
      chk("pop1_depth", {1'b0, depth}, 4'd3);
      cyc(1'b1, 1'b0, 4'h0, 1'b1, 3'b011, 1'b0, 1'b1, 1'b1, "pop2_c");
      chk("pop2_flags", flags_q, 4'b0110);
      chk("pop2_depth", {1'b0, depth}, 4'd2);
      cyc(1'b1, 1'b0, 4'h0, 1'b1, 3'b111, 1'b0, 1'b1, 1'b1, "pop3_sgt");
      chk("pop3_flags", flags_q, 4'b1001);
      chk("pop3_depth", {1'b0, depth}, 4'd1);
      cyc(1'b1, 1'b1, 4'b1111, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0, "pop4_z");
      chk("pop4_flags_we_ignored", flags_q, 4'b0000);
      chk("pop4_depth", {1'b0, depth}, 4'd0);
      cyc(1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, "");
      chk("unf_err", {3'b000, unf_err}, 4'd1);
      chk("unf_depth", {1'b0, depth}, 4'd0);
      chk("unf_flags", flags_q, 4'b0000);
      chk("ovf_sticky", {3'b000, ovf_err}, 4'd1);

      // depth 2 holding 0000, 1001; flags_q = 1001 (S=1 O=1 Z=0)
      cyc(1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "");
      cyc(1'b1, 1'b1, 4'b1001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "");
      cyc(1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "");
      cyc(1'b1, 1'b0, 4'h0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, "slt");
      cyc(1'b1, 1'b0, 4'h0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, "sgt");
      cyc(1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, "");
      chk("proto_err", {3'b000, proto_err}, 4'd1);
      chk("proto_depth", {1'b0, depth}, 4'd2);
      chk("proto_flags", flags_q, 4'b1001);
      cyc(1'b1, 1'b1, 4'b0111, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, "");
      chk("proto_we_flags", flags_q, 4'b0111);
      chk("proto_we_depth", {1'b0, depth}, 4'd2);
      cyc(1'b1, 1'b0, 4'h0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, "nz");
      cyc(1'b1, 1'b0, 4'h0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, "nc");
      cyc(1'b1, 1'b0, 4'h0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, "always");
      cyc(1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "");
      chk("pre_rst_depth", {1'b0, depth}, 4'd3);

      // reset beats a simultaneous push, write and evaluation
      cyc(1'b0, 1'b1, 4'b1111, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, "rst2");
      chk_all_zero("midreset");
      cyc(1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, "");
      chk("post_rst_unf", {3'b000, unf_err}, 4'd1);
      chk("post_rst_depth", {1'b0, depth}, 4'd0);
      chk("post_rst_flags", flags_q, 4'b0000);

      cyc(1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "");
      cyc(1'b1, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "");
      chk("sb_drained", sb_q.size() > 15 ? 4'hF : 4'(sb_q.size()), 4'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
